// File: rtl/ddr_burst_reader.sv
// DDR burst read initiator feeding a first-word-fall-through FIFO; optional abort via DDR_BURST_READER_ABORT_EN.
// Latency: first out_valid one cycle after the first rvalid beat; done one cycle after the last word handshake.
// Backpressure: a burst is issued only when the FIFO can hold all of it; a stalled out_ready holds the FSM in PLAN.

module ddr_burst_reader_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             overflow
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  // A pop in the same cycle frees the slot the push lands in.
  assign do_push  = push && (!full || do_pop);
  assign overflow = push && full && !do_pop;
  assign head     = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

module ddr_burst_reader #(
  parameter int         ADDR_BITS  = 26,
  parameter int         COL_BITS   = 11,
  parameter int         MAX_BURST  = 16,
  parameter int         FIFO_DEPTH = 64,
  parameter logic [1:0] RD_ID      = 2'd1
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef DDR_BURST_READER_ABORT_EN
  input  logic                 abort,
`endif
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] base_addr,
  input  logic [19:0]          word_count,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 arw_valid,
  input  logic                 arw_ready,
  output logic [ADDR_BITS-1:0] arw_addr,
  output logic [7:0]           arw_len,
  output logic                 arw_write,
  output logic [1:0]           arw_id,
  output logic [2:0]           arw_size,
  output logic [1:0]           arw_burst,
  input  logic                 rvalid,
  output logic                 rready,
  input  logic                 rlast,
  input  logic [31:0]          rdata,
  input  logic [1:0]           rid,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_data
);
  localparam int CW        = $clog2(FIFO_DEPTH) + 1;
  localparam int ROW_WORDS = 1 << (COL_BITS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PLAN  = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_RECV  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_FLUSH = 3'd5;

  logic [2:0]           state;
  logic [ADDR_BITS-1:0] addr;
  logic [19:0]          remaining;
  logic [8:0]           len_q;
  logic [20:0]          row_left;
  logic [20:0]          plan_len;
  logic [20:0]          fifo_free;
  logic [CW-1:0]        fifo_count;
  logic [31:0]          fifo_head;
  logic                 fifo_empty;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_clear;
  logic                 fifo_overflow;
  logic                 abort_req;
  logic                 abort_pend;
  logic                 unused_addr_lsbs;

  assign unused_addr_lsbs = &{1'b0, base_addr[1:0]};

`ifdef DDR_BURST_READER_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign arw_write = 1'b0;
  assign arw_id    = RD_ID;
  assign arw_size  = 3'b010;
  assign arw_burst = 2'b01;
  assign rready    = 1'b1;

  assign busy       = (state != S_IDLE);
  assign arw_valid  = (state == S_ISSUE);
  assign done       = ((state == S_DRAIN) && fifo_empty) || (state == S_FLUSH);
  assign out_valid  = !fifo_empty && (state != S_FLUSH);
  assign out_data   = fifo_head;
  assign fifo_pop   = out_valid && out_ready;
  assign fifo_push  = (state == S_RECV) && rvalid;
  assign fifo_clear = (state == S_FLUSH);

  // Burst length is capped by MAX_BURST, words left, and words left in the current DDR row.
  assign row_left  = 21'(ROW_WORDS) - 21'(addr[COL_BITS:2]);
  assign fifo_free = 21'(FIFO_DEPTH) - 21'(fifo_count);

  always_comb begin
    plan_len = 21'(MAX_BURST);
    if (21'(remaining) < plan_len) plan_len = 21'(remaining);
    if (row_left < plan_len)       plan_len = row_left;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      addr       <= '0;
      remaining  <= '0;
      len_q      <= '0;
      arw_addr   <= '0;
      arw_len    <= '0;
      err        <= 1'b0;
      abort_pend <= 1'b0;
    end else begin
      if ((fifo_push && (rid != RD_ID)) || fifo_overflow) err <= 1'b1;
      case (state)
        S_IDLE: begin
          if (start) begin
            addr       <= {base_addr[ADDR_BITS-1:2], 2'b00};
            remaining  <= word_count;
            abort_pend <= 1'b0;
            state      <= S_PLAN;
          end
        end
        S_PLAN: begin
          if (abort_req) begin
            state <= S_FLUSH;
          end else if (remaining == '0) begin
            state <= S_DRAIN;
          end else if (fifo_free >= plan_len) begin
            len_q    <= plan_len[8:0];
            arw_addr <= addr;
            arw_len  <= 8'(plan_len - 21'd1);
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Once the controller accepts, the burst must be received even if aborting.
          if (arw_ready) begin
            addr       <= addr + ADDR_BITS'({len_q, 2'b00});
            remaining  <= remaining - 20'(len_q);
            abort_pend <= abort_req;
            state      <= S_RECV;
          end else if (abort_req) begin
            state <= S_FLUSH;
          end
        end
        S_RECV: begin
          if (abort_req) abort_pend <= 1'b1;
          if (rvalid && rlast) state <= (abort_pend || abort_req) ? S_FLUSH : S_PLAN;
        end
        S_DRAIN: begin
          if (fifo_empty) state <= S_IDLE;
        end
        S_FLUSH: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  ddr_burst_reader_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clear     (fifo_clear),
    .push      (fifo_push),
    .push_data (rdata),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .overflow  (fifo_overflow)
  );
endmodule

// File: tb/tb_ddr_burst_reader.sv
// Scoreboarded bench: DDR slave model + consumer monitor compare against queues filled from a row/burst model.
module tb_ddr_burst_reader;
  localparam int ADDR_BITS = 26;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 start = 1'b0;
  logic [ADDR_BITS-1:0] base_addr = '0;
  logic [19:0]          word_count = '0;
  logic                 busy, done, err;
  logic                 arw_valid;
  logic                 arw_ready = 1'b0;
  logic [ADDR_BITS-1:0] arw_addr;
  logic [7:0]           arw_len;
  logic                 arw_write;
  logic [1:0]           arw_id;
  logic [2:0]           arw_size;
  logic [1:0]           arw_burst;
  logic                 rvalid = 1'b0;
  logic                 rready;
  logic                 rlast = 1'b0;
  logic [31:0]          rdata = '0;
  logic [1:0]           rid = 2'd1;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [31:0]          out_data;
`ifdef DDR_BURST_READER_ABORT_EN
  logic                 abort = 1'b0;
`endif

  ddr_burst_reader dut (
    .clk        (clk),
    .reset      (reset),
`ifdef DDR_BURST_READER_ABORT_EN
    .abort      (abort),
`endif
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .arw_valid  (arw_valid),
    .arw_ready  (arw_ready),
    .arw_addr   (arw_addr),
    .arw_len    (arw_len),
    .arw_write  (arw_write),
    .arw_id     (arw_id),
    .arw_size   (arw_size),
    .arw_burst  (arw_burst),
    .rvalid     (rvalid),
    .rready     (rready),
    .rlast      (rlast),
    .rdata      (rdata),
    .rid        (rid),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int n_bursts = 0;
  int done_cnt = 0;
  int out_mode = 1;   // 0: stall, 1: always ready, 2: random
  bit inject_rid = 1'b0;
  bit exp_err = 1'b0;

  logic [ADDR_BITS-1:0] exp_baddr[$];
  logic [7:0]           exp_blen[$];
  logic [31:0]          exp_words[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [ADDR_BITS-1:0] a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // Reference: split [base, base+4*cnt) into row-bounded bursts of at most 16 words.
  task automatic plan_xfer(input logic [ADDR_BITS-1:0] base, input int cnt);
    logic [ADDR_BITS-1:0] a;
    int rem, row_left, n;
    a = base & ~ADDR_BITS'(3);
    rem = cnt;
    while (rem > 0) begin
      row_left = 1024 - ((int'(a) / 4) % 1024);
      n = rem;
      if (n > 16) n = 16;
      if (n > row_left) n = row_left;
      exp_baddr.push_back(a);
      exp_blen.push_back(8'(n - 1));
      a = a + ADDR_BITS'(4 * n);
      rem = rem - n;
    end
    a = base & ~ADDR_BITS'(3);
    for (int i = 0; i < cnt; i++) exp_words.push_back(mem_word(a + ADDR_BITS'(4 * i)));
  endtask

  initial begin : ddr_slave
    int beats_left;
    logic [ADDR_BITS-1:0] r_addr;
    beats_left = 0;
    r_addr = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        beats_left = 0;
        rvalid = 1'b0;
        rlast = 1'b0;
        arw_ready = 1'b0;
      end else begin
        if (beats_left > 0 && $urandom_range(0, 3) != 0) begin
          rvalid = 1'b1;
          rdata = mem_word(r_addr);
          rlast = (beats_left == 1);
          rid = inject_rid ? 2'd3 : 2'd1;
          inject_rid = 1'b0;
          r_addr = r_addr + ADDR_BITS'(4);
          beats_left--;
        end else begin
          rvalid = 1'b0;
          rlast = 1'b0;
        end
        arw_ready = ($urandom_range(0, 3) != 0);
        if (arw_valid && arw_ready) begin
          n_bursts++;
          chk("burst_pending", exp_baddr.size() > 0, 1);
          if (exp_baddr.size() > 0) begin
            chk("arw_addr", arw_addr, exp_baddr.pop_front());
            chk("arw_len", arw_len, exp_blen.pop_front());
          end
          beats_left = int'(arw_len) + 1;
          r_addr = arw_addr;
        end
      end
    end
  end

  initial begin : consumer
    forever begin
      @(negedge clk);
      if (!reset) begin
        case (out_mode)
          0: out_ready = 1'b0;
          1: out_ready = 1'b1;
          default: out_ready = ($urandom_range(0, 1) == 1);
        endcase
        if (out_valid && out_ready) begin
          chk("word_pending", exp_words.size() > 0, 1);
          if (exp_words.size() > 0) chk("out_data", out_data, exp_words.pop_front());
        end
        if (done) begin
          done_cnt++;
          chk("done_after_last_word", exp_words.size(), 0);
        end
      end
    end
  end

  task automatic pulse_start(input logic [ADDR_BITS-1:0] base, input int cnt);
    plan_xfer(base, cnt);
    base_addr = base;
    word_count = 20'(cnt);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input int d0, input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done_cnt != d0) seen = 1'b1;
    end
    chk(name, seen, 1);
    repeat (4) @(negedge clk);
    chk("single_done", done_cnt - d0, 1);
    chk("bursts_all_issued", exp_baddr.size(), 0);
    chk("err_state", err, exp_err);
    chk("idle_after", busy, 0);
  endtask

  task automatic run_xfer(input logic [ADDR_BITS-1:0] base, input int cnt, input bit poke);
    int d0;
    d0 = done_cnt;
    pulse_start(base, cnt);
    if (poke) begin
      repeat (2) @(negedge clk);
      if (busy) begin
        base_addr = ADDR_BITS'($urandom);
        word_count = 20'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
    wait_done(cnt * 12 + 200, d0, "done_seen");
  endtask

  task automatic flush_model();
    exp_baddr.delete();
    exp_blen.delete();
    exp_words.delete();
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int b0, d0;
    bit seen;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_arw_valid", arw_valid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_arw_addr", arw_addr, 0);
    chk("rst_arw_len", arw_len, 0);
    chk("const_rready", rready, 1);
    chk("const_arw_write", arw_write, 0);
    chk("const_arw_id", arw_id, 1);
    chk("const_arw_size", arw_size, 3'b010);
    chk("const_arw_burst", arw_burst, 2'b01);
    reset = 1'b0;
    @(negedge clk);

    out_mode = 1;
    b0 = n_bursts;
    run_xfer(26'h1000, 40, 1'b0);
    chk("t1_burst_count", n_bursts - b0, 3);

    b0 = n_bursts;
    run_xfer(26'hFF8, 8, 1'b0);
    chk("t2_burst_count", n_bursts - b0, 2);

    b0 = n_bursts;
    d0 = done_cnt;
    base_addr = 26'h500;
    word_count = 20'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("zero_done_c1", done, 0);
    chk("zero_busy_c1", busy, 1);
    @(negedge clk);
    chk("zero_done_c2", done, 1);
    @(negedge clk);
    chk("zero_done_c3", done, 0);
    chk("zero_busy_c3", busy, 0);
    chk("zero_no_burst", n_bursts - b0, 0);

    out_mode = 0;
    b0 = n_bursts;
    d0 = done_cnt;
    pulse_start(26'h2000, 100);
    repeat (300) @(negedge clk);
    chk("stall_bursts", n_bursts - b0, 4);
    chk("stall_arw_valid", arw_valid, 0);
    chk("stall_busy", busy, 1);
    chk("stall_out_valid", out_valid, 1);
    out_mode = 1;
    wait_done(1500, d0, "stall_done");
    chk("stall_total_bursts", n_bursts - b0, 7);

    out_mode = 2;
    inject_rid = 1'b1;
    exp_err = 1'b1;
    run_xfer(26'h0840, 30, 1'b0);
    repeat (5) @(negedge clk);
    chk("err_sticky", err, 1);
    #2 reset = 1'b1;
    #1 chk("err_cleared", err, 0);
    exp_err = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    out_mode = 1;
    pulse_start(26'h3000, 64);
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (rvalid) seen = 1'b1;
    end
    chk("recv_reached", seen, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_arw_valid", arw_valid, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_arw_addr", arw_addr, 0);
    chk("mid_rst_arw_len", arw_len, 0);
    flush_model();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_xfer(26'h3000, 64, 1'b0);

    out_mode = 2;
    for (int t = 0; t < 8; t++) begin
      logic [ADDR_BITS-1:0] base;
      int cnt;
      base = ADDR_BITS'($urandom_range(0, 200) * 4096);
      if ($urandom_range(0, 1) == 1) base = base + ADDR_BITS'(4 * $urandom_range(990, 1023));
      else base = base + ADDR_BITS'(4 * $urandom_range(0, 1023));
      base = base + ADDR_BITS'($urandom_range(0, 3));
      cnt = $urandom_range(1, 120);
      run_xfer(base, cnt, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ddr_burst_reader.md
Name: ddr_burst_reader

Overview:
- AXI-style read initiator for the DDR SDRAM controller's combined address channel (`arw_*`) and its read-data channel (`r*`).
- Fetches a linear word region from DDR as a sequence of INCR bursts and buffers the data in an internal FIFO.
- Presents the data as a valid/ready word stream to a consumer (video scan-out, DMA).
- The controller ignores `rready` once a burst is accepted, so this block must reserve FIFO space before issuing each burst.

Parameters:
- ADDR_BITS, 26, byte-address width; equals controller ROW_BITS+COL_BITS+3.
- COL_BITS, 11, controller column bits; a row spans 2^(COL_BITS+1) bytes = 1024 words.
- MAX_BURST, 16, maximum beats per burst (1..256).
- FIFO_DEPTH, 64, output FIFO depth in 32-bit words (power of 2, >= MAX_BURST).
- RD_ID, 2'd1, value driven on `arw_id` and expected on `rid`.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request to begin a transfer
- base_addr  in  ADDR_BITS  start byte address; bits [1:0] ignored
- word_count  in  20  number of 32-bit words to fetch
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse when the last word is accepted by the consumer
- err  out  1  sticky: `rid` mismatch, or overflow write into a full FIFO
- arw_valid  out  1  address request valid
- arw_ready  in  1  controller accepts request
- arw_addr  out  ADDR_BITS  burst start byte address
- arw_len  out  8  beats minus 1
- arw_write  out  1  constant 0
- arw_id  out  2  constant RD_ID
- arw_size  out  3  constant 3'b010
- arw_burst  out  2  constant 2'b01 (INCR)
- rvalid  in  1  read beat valid
- rready  out  1  constant 1
- rlast  in  1  last beat of burst
- rdata  in  32  read data
- rid  in  2  read ID
- out_valid  out  1  stream word valid
- out_ready  in  1  consumer accepts word
- out_data  out  32  stream word

Behaviour:
- Reset (async) clears all state:
  - FSM to IDLE; counters and FIFO to empty.
  - `busy`, `done`, `err`, `arw_valid`, `out_valid` = 0; `arw_addr`, `arw_len` = 0.
  - If reset is asserted mid-burst, in-flight beats are lost; the controller must share the same reset.
- FSM states:
  - IDLE: on `start`, latch `addr = {base_addr[ADDR_BITS-1:2], 2'b00}` and `remaining = word_count`, then go to PLAN. `busy`=1 from the cycle after `start` until `done`. `start` while `busy` is ignored.
  - PLAN (1 cycle):
    - `row_left = 1024 - addr[COL_BITS:2]`.
    - `len = min(MAX_BURST, remaining, row_left)`; bursts never cross a row boundary.
    - If `remaining == 0`, go to DRAIN.
    - Else, if `FIFO_DEPTH - fifo_count >= len`, go to ISSUE; otherwise stay in PLAN.
  - ISSUE: `arw_valid`=1, `arw_addr=addr`, `arw_len=len-1`, all held stable until `arw_ready`. On the handshake: `addr += 4*len`, `remaining -= len`, go to RECV.
  - RECV: every `rvalid` beat writes `rdata` into the FIFO. The `rvalid && rlast` beat returns to PLAN. The beat count is not checked against `len`; `rlast` governs.
  - DRAIN: wait until the FIFO is empty with the final word handshaken; `done`=1 for one cycle in the cycle after the last `out_valid && out_ready`; go to IDLE.
- At most one burst is outstanding.
- `word_count == 0`: PLAN, then DRAIN, then `done` 2 cycles after `start`; no `arw_valid` is issued.
- FIFO:
  - Synchronous, first-word-fall-through: `out_valid = !empty`, `out_data` = head word.
  - Simultaneous push and pop when full is legal (pop frees the slot).
  - A push while full with no pop sets `err` and the word is dropped.
  - `rid != RD_ID` on any beat sets `err`; the beat is still stored.
  - `err` clears only on reset.
- Latency: first `out_valid` appears 1 cycle after the first `rvalid` beat.

Optional Feature:
- Macro: DDR_BURST_READER_ABORT_EN.
- Defined:
  - Adds input `abort` (1 bit).
  - `abort` in PLAN or ISSUE goes directly to the flush. In ISSUE, `arw_valid` may drop only if `arw_ready` is not asserted in that same cycle; if it is, the burst is accepted and must be received first.
  - `abort` in RECV finishes the current burst first.
  - Flush: FIFO contents are discarded, `out_valid`=0, `done` pulses, return to IDLE.
- Undefined: no `abort` port; a transfer always runs to completion.

Test Plan:
- base_addr=0x1000, word_count=40, `arw_ready` and `out_ready` always 1 → bursts (0x1000, len 15), (0x1040, 15), (0x1080, 7); 40 words in order; one `done` pulse; `err`=0.
- base_addr=0xFF8 (word 1022 of row 0), word_count=8 → bursts (0xFF8, len 1) then (0x1000, len 5); no burst crosses the 4 KB boundary.
- word_count=0 → no `arw_valid`; `done` exactly 2 cycles after `start`.
- FIFO_DEPTH=64, `out_ready`=0, word_count=100 → 4 bursts of 16 issued (64 words), then stalled in PLAN with `arw_valid`=0. Release `out_ready` → remaining 36 words fetched; no `err`.
- `rid`=2'd3 injected on one beat → `err`=1 sticky; transfer still completes; reset clears `err`.
- Async reset asserted mid-RECV → all outputs 0 immediately; a new `start` afterwards runs cleanly (with DDR_BURST_READER_ABORT_EN: `abort` mid-RECV → burst finishes, FIFO emptied, `done` pulses).
